// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue controller: M-extension funct3
// codes, controller state encoding and a small op-decode helper.
package div_issue_ctrl_pkg;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPEC  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4
   } div_state_t;

   // True for one of the four encodings the divider understands.
   function automatic logic is_div_op(input logic [2:0] funct3);
      return (funct3[2] == 1'b1);
   endfunction

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of RISC-V divide corner cases that are resolved
// without the iterative divider: divide by zero, signed overflow
// (INT_MIN / -1) and unsupported funct3 codes (result forced to zero).
// Zero divisor is checked before overflow.
module div_special_detect
   import div_issue_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            is_special,
   output logic [XLEN-1:0] special_result
);

   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

   logic div_by_zero_s;
   logic overflow_s;

   // Operand classification shared by all op types.
   always_comb begin
      div_by_zero_s = (rs2 == ZERO);
      overflow_s    = (rs1 == INT_MIN) && (rs2 == ALL_ONES);
   end

   // Select the architectural result for each special case.
   always_comb begin
      is_special     = 1'b0;
      special_result = ZERO;
      if (!is_div_op(funct3)) begin
         is_special     = 1'b1;
         special_result = ZERO;
      end else begin
         case (funct3)
            F3_DIV: begin
               if (div_by_zero_s) begin
                  is_special     = 1'b1;
                  special_result = ALL_ONES;
               end else if (overflow_s) begin
                  is_special     = 1'b1;
                  special_result = INT_MIN;
               end else begin
                  is_special     = 1'b0;
                  special_result = ZERO;
               end
            end
            F3_DIVU: begin
               if (div_by_zero_s) begin
                  is_special     = 1'b1;
                  special_result = ALL_ONES;
               end else begin
                  is_special     = 1'b0;
                  special_result = ZERO;
               end
            end
            F3_REM: begin
               if (div_by_zero_s) begin
                  is_special     = 1'b1;
                  special_result = rs1;
               end else if (overflow_s) begin
                  is_special     = 1'b1;
                  special_result = ZERO;
               end else begin
                  is_special     = 1'b0;
                  special_result = ZERO;
               end
            end
            F3_REMU: begin
               if (div_by_zero_s) begin
                  is_special     = 1'b1;
                  special_result = rs1;
               end else begin
                  is_special     = 1'b0;
                  special_result = ZERO;
               end
            end
            default: begin
               is_special     = 1'b1;
               special_result = ZERO;
            end
         endcase
      end
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// Divide issue controller for the EX stage. Accepts one M-extension divide
// op, answers special cases in one cycle, otherwise launches the shared
// iterative divider and waits for its completion pulse. A flush while the
// divider runs drains it (the divider cannot abort); a watchdog recovers
// from a hung divider and raises a sticky error.
// Optional feature macro: DIV_RESULT_CACHE_EN (one-entry result cache that
// turns an exact repeat of the last divider op into a one-cycle hit).
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic             sys_clk,
   input  logic             sys_reset_n,
   input  logic             ex_valid_i,
   output logic             ex_ready_o,
   input  logic             ex_flush_i,
   input  logic [2:0]       ex_funct3_i,
   input  logic [XLEN-1:0]  ex_rs1_i,
   input  logic [XLEN-1:0]  ex_rs2_i,
   input  logic [TAG_W-1:0] ex_tag_i,
   output logic             res_valid_o,
   output logic [XLEN-1:0]  res_data_o,
   output logic [TAG_W-1:0] res_tag_o,
   output logic             busy_o,
   output logic             err_o,
   output logic             div_start_o,
   output logic             div_reset_o,
   output logic [XLEN-1:0]  div_dividend_o,
   output logic [XLEN-1:0]  div_divisor_o,
   output logic [2:0]       div_funct3_o,
   input  logic [XLEN-1:0]  div_result_i,
   input  logic             div_complete_i
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   div_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       f3_r;
   logic [XLEN-1:0]  rs1_r;
   logic [XLEN-1:0]  rs2_r;
   logic [TAG_W-1:0] tag_r;
   logic [XLEN-1:0]  spec_res_r;
   logic             res_valid_r;
   logic [XLEN-1:0]  res_data_r;
   logic [TAG_W-1:0] res_tag_r;
   logic             busy_r;
   logic             ready_r;
   logic             err_r;
   logic             start_r;
   logic             dreset_r;

   logic             is_special_s;
   logic [XLEN-1:0]  special_result_s;
   logic             cache_hit_s;
   logic [XLEN-1:0]  cache_res_s;
   logic             accept_s;
   logic             complete_ok_s;
   logic             complete_drop_s;
   logic             drain_done_s;
   logic             wdog_s;
   logic             to_drain_s;

   div_special_detect #(.XLEN(XLEN)) u_special (
      .funct3         (ex_funct3_i),
      .rs1            (ex_rs1_i),
      .rs2            (ex_rs2_i),
      .is_special     (is_special_s),
      .special_result (special_result_s)
   );

   // Decode handshake and completion/watchdog events from the current state.
   always_comb begin
      accept_s        = ex_valid_i & ready_r & ~ex_flush_i;
      complete_ok_s   = (state_r == ST_WAIT) & div_complete_i & ~ex_flush_i;
      complete_drop_s = (state_r == ST_WAIT) & div_complete_i & ex_flush_i;
      drain_done_s    = (state_r == ST_DRAIN) & div_complete_i;
      wdog_s          = ((state_r == ST_WAIT) | (state_r == ST_DRAIN)) &
                        ~div_complete_i & (cnt_r == CNT_LAST);
      to_drain_s      = ((state_r == ST_START) & ex_flush_i) |
                        ((state_r == ST_WAIT) & ex_flush_i & ~div_complete_i & ~wdog_s);
   end

`ifdef DIV_RESULT_CACHE_EN
   logic             cache_vld_r;
   logic [2:0]       cache_f3_r;
   logic [XLEN-1:0]  cache_rs1_r;
   logic [XLEN-1:0]  cache_rs2_r;
   logic [XLEN-1:0]  cache_data_r;

   // Hit when the offered op exactly repeats the last divider op.
   always_comb begin
      cache_hit_s = cache_vld_r & (cache_f3_r == ex_funct3_i) &
                    (cache_rs1_r == ex_rs1_i) & (cache_rs2_r == ex_rs2_i);
      cache_res_s = cache_data_r;
   end

   // Capture every delivered divider result; drop the entry on abnormal ends.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         cache_vld_r  <= 1'b0;
         cache_f3_r   <= 3'b000;
         cache_rs1_r  <= {XLEN{1'b0}};
         cache_rs2_r  <= {XLEN{1'b0}};
         cache_data_r <= {XLEN{1'b0}};
      end else if (wdog_s | to_drain_s) begin
         cache_vld_r  <= 1'b0;
      end else if (complete_ok_s) begin
         cache_vld_r  <= 1'b1;
         cache_f3_r   <= f3_r;
         cache_rs1_r  <= rs1_r;
         cache_rs2_r  <= rs2_r;
         cache_data_r <= div_result_i;
      end
   end
`else
   // Without the cache every non-special op goes to the divider.
   always_comb begin
      cache_hit_s = 1'b0;
      cache_res_s = {XLEN{1'b0}};
   end
`endif

   // Controller FSM with all outputs registered.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         f3_r        <= 3'b000;
         rs1_r       <= {XLEN{1'b0}};
         rs2_r       <= {XLEN{1'b0}};
         tag_r       <= {TAG_W{1'b0}};
         spec_res_r  <= {XLEN{1'b0}};
         res_valid_r <= 1'b0;
         res_data_r  <= {XLEN{1'b0}};
         res_tag_r   <= {TAG_W{1'b0}};
         busy_r      <= 1'b0;
         ready_r     <= 1'b1;
         err_r       <= 1'b0;
         start_r     <= 1'b0;
         dreset_r    <= 1'b0;
      end else begin
         res_valid_r <= 1'b0;
         start_r     <= 1'b0;
         dreset_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  f3_r       <= ex_funct3_i;
                  rs1_r      <= ex_rs1_i;
                  rs2_r      <= ex_rs2_i;
                  tag_r      <= ex_tag_i;
                  spec_res_r <= is_special_s ? special_result_s : cache_res_s;
                  state_r    <= (is_special_s | cache_hit_s) ? ST_SPEC : ST_START;
                  busy_r     <= 1'b1;
                  ready_r    <= 1'b0;
               end
            end
            ST_SPEC: begin
               res_valid_r <= 1'b1;
               res_data_r  <= spec_res_r;
               res_tag_r   <= tag_r;
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
               ready_r     <= 1'b1;
            end
            ST_START: begin
               start_r <= 1'b1;
               cnt_r   <= CNT_ZERO;
               state_r <= to_drain_s ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (complete_ok_s) begin
                  res_valid_r <= 1'b1;
                  res_data_r  <= div_result_i;
                  res_tag_r   <= tag_r;
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
                  ready_r     <= 1'b1;
               end else if (complete_drop_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else if (wdog_s) begin
                  err_r    <= 1'b1;
                  dreset_r <= 1'b1;
                  state_r  <= ST_IDLE;
                  busy_r   <= 1'b0;
                  ready_r  <= 1'b1;
               end else if (to_drain_s) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (drain_done_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else if (wdog_s) begin
                  err_r    <= 1'b1;
                  dreset_r <= 1'b1;
                  state_r  <= ST_IDLE;
                  busy_r   <= 1'b0;
                  ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   // Drive ports straight from the registers.
   always_comb begin
      ex_ready_o     = ready_r;
      res_valid_o    = res_valid_r;
      res_data_o     = res_data_r;
      res_tag_o      = res_tag_r;
      busy_o         = busy_r;
      err_o          = err_r;
      div_start_o    = start_r;
      div_reset_o    = dreset_r;
      div_dividend_o = rs1_r;
      div_divisor_o  = rs2_r;
      div_funct3_o   = f3_r;
   end

endmodule
